// File: rtl/crp16_alu_cmp_seq_if.sv
// Request/response bundle for the CRP16 multi-cycle set-compare unit.
// The requester uses the master modport and the compare unit uses the slave modport.
interface crp16_alu_cmp_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, x, y,
      input  busy, done, result
   );

   modport slave (
      input  start, op, x, y,
      output busy, done, result
   );
endinterface

// File: rtl/crp16_alu_cmp_seq.sv
// CRP16 set-compare unit (SLTU/SLT/SEQ/SNE): evaluates x - y one CHUNK per cycle, LSB first,
// and returns the predicate zero-extended to WIDTH with a start/busy/done handshake.
module crp16_alu_cmp_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic                clk_i,
   input logic                reset_i,
   crp16_alu_cmp_seq_if.slave bus
);
   localparam int N      = WIDTH / CHUNK;
   localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

   localparam logic [1:0] OP_SLTU = 2'b00;
   localparam logic [1:0] OP_SLT  = 2'b01;
   localparam logic [1:0] OP_SEQ  = 2'b10;
   localparam logic [1:0] OP_SNE  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   generate
      if ((WIDTH % CHUNK) != 0 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_param
         $error("crp16_alu_cmp_seq: CHUNK must divide WIDTH");
      end
   endgenerate

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  x_q, x_d;
   logic [WIDTH-1:0]  y_q, y_d;
   logic [1:0]        op_q, op_d;
   logic              carry_q, carry_d;
   logic              neq_q, neq_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [WIDTH-1:0]  result_q, result_d;

   logic [CHUNK-1:0]  xk_s;
   logic [CHUNK-1:0]  yk_s;
   logic [1:0]        top_s;
   logic              neq_next_s;
   logic              pred_s;

   // Operands are consumed from the bottom and shifted down, so the current chunk is always the low slice.
   // top_s keeps only the chunk carry-out and the difference MSB of this beat.
   always_comb begin
      xk_s       = x_q[CHUNK-1:0];
      yk_s       = y_q[CHUNK-1:0];
      top_s      = 2'(({1'b0, xk_s} + {1'b0, ~yk_s} + (CHUNK+1)'(carry_q)) >> (CHUNK - 1));
      neq_next_s = neq_q | (xk_s != yk_s);
   end

   // Predicate from the last beat; the signed form uses the sign bits to stay correct across overflow.
   always_comb begin
      pred_s = 1'b0;
      case (op_q)
         OP_SLTU: pred_s = ~top_s[1];
         OP_SLT:  pred_s = (xk_s[CHUNK-1] ^ yk_s[CHUNK-1]) ? xk_s[CHUNK-1] : top_s[0];
         OP_SEQ:  pred_s = ~neq_next_s;
         OP_SNE:  pred_s = neq_next_s;
         default: pred_s = 1'b0;
      endcase
   end

   // Next-state and datapath update; an accepted start in IDLE or DONE reloads everything.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      op_d     = op_q;
      carry_d  = carry_q;
      neq_d    = neq_q;
      beat_d   = beat_q;
      result_d = result_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_RUN;
               x_d     = bus.x;
               y_d     = bus.y;
               op_d    = bus.op;
               carry_d = 1'b1;
               neq_d   = 1'b0;
               beat_d  = {BEAT_W{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            x_d     = x_q >> CHUNK;
            y_d     = y_q >> CHUNK;
            carry_d = top_s[1];
            neq_d   = neq_next_s;
            beat_d  = beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) begin
               state_d  = S_DONE;
               result_d = WIDTH'(pred_s);
            end else begin
               state_d  = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         x_q      <= {WIDTH{1'b0}};
         y_q      <= {WIDTH{1'b0}};
         op_q     <= 2'b00;
         carry_q  <= 1'b0;
         neq_q    <= 1'b0;
         beat_q   <= {BEAT_W{1'b0}};
         result_q <= {WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         op_q     <= op_d;
         carry_q  <= carry_d;
         neq_q    <= neq_d;
         beat_q   <= beat_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = (state_q == S_RUN);
   assign bus.done   = (state_q == S_DONE);
   assign bus.result = result_q;
endmodule

// File: tb/tb_crp16_alu_cmp_seq.sv
// Directed and model-checked bench for crp16_alu_cmp_seq at CHUNK = 1, 4 and 16 (WIDTH = 16).
module tb_crp16_alu_cmp_seq;
   localparam int W = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   crp16_alu_cmp_seq_if #(.WIDTH(W)) bus1  ();
   crp16_alu_cmp_seq_if #(.WIDTH(W)) bus4  ();
   crp16_alu_cmp_seq_if #(.WIDTH(W)) bus16 ();

   crp16_alu_cmp_seq #(.WIDTH(W), .CHUNK(1))  u_dut1  (.clk_i(clk), .reset_i(reset), .bus(bus1.slave));
   crp16_alu_cmp_seq #(.WIDTH(W), .CHUNK(4))  u_dut4  (.clk_i(clk), .reset_i(reset), .bus(bus4.slave));
   crp16_alu_cmp_seq #(.WIDTH(W), .CHUNK(16)) u_dut16 (.clk_i(clk), .reset_i(reset), .bus(bus16.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         2'b00:   return {15'd0, (a < b)};
         2'b01:   return {15'd0, ($signed(a) < $signed(b))};
         2'b10:   return {15'd0, (a == b)};
         default: return {15'd0, (a != b)};
      endcase
   endfunction

   // One op on the CHUNK=4 unit; operands are scrambled after the start to prove they were latched.
   task automatic run4(input string tag, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp);
      int dc;
      dc = 0;
      bus4.start = 1'b1; bus4.op = op; bus4.x = a; bus4.y = b;
      tick();
      bus4.start = 1'b0; bus4.op = ~op; bus4.x = ~a; bus4.y = ~b;
      for (int c = 1; c <= 20 && dc == 0; c++) begin
         if (bus4.done) dc = c;
         else tick();
      end
      chk({tag, "_cyc"}, dc, 5);
      chk({tag, "_res"}, bus4.result, exp);
      tick();
   endtask

   initial begin
      logic [1:0]  op;
      logic [15:0] a, b, exp;
      int d1, d4, d16, dc, ndone;
      logic [15:0] r1, r4, r16;

      bus1.start  = 1'b0; bus1.op  = 2'b00; bus1.x  = 16'h0000; bus1.y  = 16'h0000;
      bus4.start  = 1'b0; bus4.op  = 2'b00; bus4.x  = 16'h0000; bus4.y  = 16'h0000;
      bus16.start = 1'b0; bus16.op = 2'b00; bus16.x = 16'h0000; bus16.y = 16'h0000;
      reset = 1'b1;
      tick();
      tick();
      chk("rst_busy", bus4.busy, 0);
      chk("rst_done", bus4.done, 0);
      chk("rst_res",  bus4.result, 0);
      chk("rst_res1", bus1.result, 0);
      reset = 1'b0;

      // Test 1: exact cycle timing for SLTU 1 < 0xFFFF.
      bus4.start = 1'b1; bus4.op = 2'b00; bus4.x = 16'h0001; bus4.y = 16'hFFFF;
      tick();
      bus4.start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("t1_busy_c%0d", c), bus4.busy, 1);
         chk($sformatf("t1_done_c%0d", c), bus4.done, 0);
         tick();
      end
      chk("t1_done_c5", bus4.done, 1);
      chk("t1_busy_c5", bus4.busy, 0);
      chk("t1_res_c5",  bus4.result, 16'h0001);
      tick();
      chk("t1_done_c6", bus4.done, 0);
      chk("t1_res_c6",  bus4.result, 16'h0001);

      // Tests 2-4: directed predicates, results alternate so a stale result is visible.
      run4("slt_neg",  2'b01, 16'hFFFF, 16'h0001, 16'h0001);
      run4("sltu_big", 2'b00, 16'hFFFF, 16'h0001, 16'h0000);
      run4("slt_ovf1", 2'b01, 16'h8000, 16'h7FFF, 16'h0001);
      run4("slt_ovf0", 2'b01, 16'h7FFF, 16'h8000, 16'h0000);
      run4("seq_eq",   2'b10, 16'h1234, 16'h1234, 16'h0001);
      run4("seq_ne",   2'b10, 16'h1234, 16'h1235, 16'h0000);
      run4("sne_lo",   2'b11, 16'h1234, 16'h1235, 16'h0001);
      run4("sne_hi",   2'b11, 16'h5555, 16'h5555, 16'h0000);
      run4("sltu_hi",  2'b00, 16'h7FFF, 16'h8000, 16'h0001);
      run4("slt_eq",   2'b01, 16'h8000, 16'h8000, 16'h0000);

      // Test 5a: start during RUN is ignored, operand changes after start have no effect.
      bus4.start = 1'b1; bus4.op = 2'b00; bus4.x = 16'h0001; bus4.y = 16'hFFFF;
      tick();
      bus4.start = 1'b0; bus4.op = 2'b01; bus4.x = 16'hFFFF; bus4.y = 16'h0001;
      tick();
      bus4.start = 1'b1; bus4.op = 2'b00; bus4.x = 16'h0005; bus4.y = 16'h0003;
      tick();
      bus4.start = 1'b0;
      tick();
      tick();
      chk("t5a_done_c5", bus4.done, 1);
      chk("t5a_res_c5",  bus4.result, 16'h0001);
      tick();
      chk("t5a_done_c6", bus4.done, 0);
      chk("t5a_busy_c6", bus4.busy, 0);
      tick();
      chk("t5a_done_c7", bus4.done, 0);
      chk("t5a_res_c7",  bus4.result, 16'h0001);

      // Test 5b: start in the DONE cycle chains the next op; done again at cycle 10.
      bus4.start = 1'b1; bus4.op = 2'b00; bus4.x = 16'hFFFF; bus4.y = 16'h0001;
      tick();
      bus4.start = 1'b0;
      tick(); tick(); tick(); tick();
      chk("t5b_done_c5", bus4.done, 1);
      chk("t5b_res_c5",  bus4.result, 16'h0000);
      bus4.start = 1'b1; bus4.op = 2'b01; bus4.x = 16'hFFFF; bus4.y = 16'h0001;
      tick();
      bus4.start = 1'b0;
      chk("t5b_busy_c6", bus4.busy, 1);
      chk("t5b_res_c6",  bus4.result, 16'h0000);
      dc = 0;
      for (int c = 6; c <= 25 && dc == 0; c++) begin
         if (bus4.done) dc = c;
         else tick();
      end
      chk("t5b_cyc", dc, 10);
      chk("t5b_res", bus4.result, 16'h0001);
      tick();

      // Test 5c: reset in cycle 3 aborts the op with no done pulse.
      bus4.start = 1'b1; bus4.op = 2'b10; bus4.x = 16'hABCD; bus4.y = 16'hABCD;
      tick();
      bus4.start = 1'b0;
      tick();
      tick();
      chk("t5c_busy_c3", bus4.busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5c_busy_c4", bus4.busy, 0);
      chk("t5c_done_c4", bus4.done, 0);
      chk("t5c_res_c4",  bus4.result, 16'h0000);
      ndone = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus4.done) ndone++;
      end
      chk("t5c_no_done", ndone, 0);

      // Test 6: random sweep on all three chunk sizes against the behavioural model.
      for (int i = 0; i < 2000; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = 16'($urandom);
         case (i % 8)
            0:       b = a;
            1:       b = a ^ 16'h8000;
            2:       b = a ^ 16'h0001;
            default: b = 16'($urandom);
         endcase
         exp = model(op, a, b);
         bus1.start  = 1'b1; bus1.op  = op; bus1.x  = a; bus1.y  = b;
         bus4.start  = 1'b1; bus4.op  = op; bus4.x  = a; bus4.y  = b;
         bus16.start = 1'b1; bus16.op = op; bus16.x = a; bus16.y = b;
         tick();
         bus1.start  = 1'b0; bus1.x  = ~a; bus1.y  = a;
         bus4.start  = 1'b0; bus4.x  = ~a; bus4.y  = a;
         bus16.start = 1'b0; bus16.x = ~a; bus16.y = a;
         d1 = 0; d4 = 0; d16 = 0; r1 = 16'h0; r4 = 16'h0; r16 = 16'h0;
         for (int c = 1; c <= 18; c++) begin
            if (bus1.done  && d1  == 0) begin d1  = c; r1  = bus1.result;  end
            if (bus4.done  && d4  == 0) begin d4  = c; r4  = bus4.result;  end
            if (bus16.done && d16 == 0) begin d16 = c; r16 = bus16.result; end
            tick();
         end
         chk($sformatf("sw1_cyc_%0d",  i), d1,  17);
         chk($sformatf("sw4_cyc_%0d",  i), d4,  5);
         chk($sformatf("sw16_cyc_%0d", i), d16, 2);
         chk($sformatf("sw1_res_%0d_op%0d",  i, op), r1,  exp);
         chk($sformatf("sw4_res_%0d_op%0d",  i, op), r4,  exp);
         chk($sformatf("sw16_res_%0d_op%0d", i, op), r16, exp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
